// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
package vga_pkg;

    typedef enum logic [1:0] {DISP, FP, PULSE, BP} region_t;
    typedef enum logic {IDLE, RUN} run_state_t;

    localparam int H_DISP_DEF  = 640;
    localparam int H_FP_DEF    = 16;
    localparam int H_PULSE_DEF = 96;
    localparam int H_BP_DEF    = 48;

    localparam int V_DISP_DEF  = 480;
    localparam int V_FP_DEF    = 10;
    localparam int V_PULSE_DEF = 2;
    localparam int V_BP_DEF    = 33;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap flag and region decode.
module vga_axis_counter #(
    parameter int DISP  = 640,
    parameter int FP    = 16,
    parameter int PULSE = 96,
    parameter int BP    = 48,
    localparam int TOTAL = DISP + FP + PULSE + BP,
    localparam int W     = $clog2(TOTAL)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             step,
    input  logic             clear,
    output logic [W-1:0]     count,
    output vga_pkg::region_t region,
    output logic             wrap
);
    import vga_pkg::*;

    localparam logic [W-1:0] C_DISP_END  = W'(DISP);
    localparam logic [W-1:0] C_FP_END    = W'(DISP + FP);
    localparam logic [W-1:0] C_PULSE_END = W'(DISP + FP + PULSE);
    localparam logic [W-1:0] C_LAST      = W'(TOTAL - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (!RST || clear) begin
            r_count <= '0;
        end else if (step) begin
            r_count <= (r_count == C_LAST) ? '0 : r_count + W'(1);
        end
    end

    always_comb begin
        region = vga_pkg::BP;
        if (r_count < C_DISP_END) begin
            region = vga_pkg::DISP;
        end else if (r_count < C_FP_END) begin
            region = vga_pkg::FP;
        end else if (r_count < C_PULSE_END) begin
            region = vga_pkg::PULSE;
        end
    end

    assign count = r_count;
    assign wrap  = (r_count == C_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator with frame-boundary run/stop.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   HDISP  = H_DISP_DEF,
    parameter int   HFP    = H_FP_DEF,
    parameter int   HPULSE = H_PULSE_DEF,
    parameter int   HBP    = H_BP_DEF,
    parameter int   VDISP  = V_DISP_DEF,
    parameter int   VFP    = V_FP_DEF,
    parameter int   VPULSE = V_PULSE_DEF,
    parameter int   VBP    = V_BP_DEF,
    parameter logic HS_POL = 1'b0,
    parameter logic VS_POL = 1'b0,
`ifdef VGA_TIMING_FRAME_CNT_EN
    parameter int   FCW    = 16,
`endif
    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP,
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP,
    localparam int XW     = $clog2(HTOTAL),
    localparam int YW     = $clog2(VTOTAL)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ENABLE,
    output logic          VGA_CLK,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK,
    output logic          VGA_SYNC,
    output logic          DE,
    output logic [XW-1:0] X,
    output logic [YW-1:0] Y,
    output logic          SOF,
    output logic          EOL
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FCW-1:0] FRAME_CNT
`endif
);

    run_state_t    r_state;
    run_state_t    w_next;
    logic          w_run;
    logic [XW-1:0] w_hc;
    logic [YW-1:0] w_vc;
    region_t       w_hreg;
    region_t       w_vreg;
    logic          w_hwrap;
    logic          w_vwrap;
    logic          w_origin;

    logic          r_hs;
    logic          r_vs;
    logic          r_de;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_sof;
    logic          r_eol;

    assign w_run    = (r_state == RUN);
    assign w_origin = (w_hc == '0) && (w_vc == '0);

    vga_axis_counter #(
        .DISP (HDISP),
        .FP   (HFP),
        .PULSE(HPULSE),
        .BP   (HBP)
    ) u_h (
        .CLK   (CLK),
        .RST   (RST),
        .step  (w_run),
        .clear (!w_run),
        .count (w_hc),
        .region(w_hreg),
        .wrap  (w_hwrap)
    );

    vga_axis_counter #(
        .DISP (VDISP),
        .FP   (VFP),
        .PULSE(VPULSE),
        .BP   (VBP)
    ) u_v (
        .CLK   (CLK),
        .RST   (RST),
        .step  (w_run && w_hwrap),
        .clear (!w_run),
        .count (w_vc),
        .region(w_vreg),
        .wrap  (w_vwrap)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Stop is only honoured on the last pixel so a frame is never truncated.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (ENABLE) w_next = RUN;
            RUN:  if (w_hwrap && w_vwrap && !ENABLE) w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST || !w_run) begin
            r_hs  <= ~HS_POL;
            r_vs  <= ~VS_POL;
            r_de  <= 1'b0;
            r_x   <= '0;
            r_y   <= '0;
            r_sof <= 1'b0;
            r_eol <= 1'b0;
        end else begin
            r_hs  <= (w_hreg == PULSE) ? HS_POL : ~HS_POL;
            r_vs  <= (w_vreg == PULSE) ? VS_POL : ~VS_POL;
            r_de  <= (w_hreg == DISP) && (w_vreg == DISP);
            r_x   <= w_hc;
            r_y   <= w_vc;
            r_sof <= w_origin;
            r_eol <= w_hwrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FCW-1:0] r_fcnt;
    logic           r_seen;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_fcnt <= '0;
            r_seen <= 1'b0;
        end else if (w_run && w_origin) begin
            if (r_seen) r_fcnt <= r_fcnt + FCW'(1);
            r_seen <= 1'b1;
        end
    end

    assign FRAME_CNT = r_fcnt;
`endif

    assign VGA_CLK   = CLK;
    assign VGA_SYNC  = 1'b0;
    assign VGA_HS    = r_hs;
    assign VGA_VS    = r_vs;
    assign VGA_BLANK = r_de;
    assign DE        = r_de;
    assign X         = r_x;
    assign Y         = r_y;
    assign SOF       = r_sof;
    assign EOL       = r_eol;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: small 8x6 mode checked pixel by pixel, default mode per line.
module tb_vga_timing_gen;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic s_en = 1'b0;
    logic d_en = 1'b0;

    always #5 CLK = ~CLK;

    logic       s_vclk, s_hs, s_vs, s_blank, s_sync, s_de, s_sof, s_eol;
    logic [2:0] s_x, s_y;
    logic       d_vclk, d_hs, d_vs, d_blank, d_sync, d_de, d_sof, d_eol;
    logic [9:0] d_x, d_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [1:0]  s_fc;
    logic [15:0] d_fc;
`endif

    vga_timing_gen #(
        .HDISP(4), .HFP(1), .HPULSE(2), .HBP(1),
        .VDISP(3), .VFP(1), .VPULSE(1), .VBP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .FCW(2)
`endif
    ) u_small (
        .CLK(CLK), .RST(RST), .ENABLE(s_en),
        .VGA_CLK(s_vclk), .VGA_HS(s_hs), .VGA_VS(s_vs),
        .VGA_BLANK(s_blank), .VGA_SYNC(s_sync), .DE(s_de),
        .X(s_x), .Y(s_y), .SOF(s_sof), .EOL(s_eol)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .FRAME_CNT(s_fc)
`endif
    );

    vga_timing_gen u_def (
        .CLK(CLK), .RST(RST), .ENABLE(d_en),
        .VGA_CLK(d_vclk), .VGA_HS(d_hs), .VGA_VS(d_vs),
        .VGA_BLANK(d_blank), .VGA_SYNC(d_sync), .DE(d_de),
        .X(d_x), .Y(d_y), .SOF(d_sof), .EOL(d_eol)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .FRAME_CNT(d_fc)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;
    int mx = 0;
    int my = 0;
    int n_sof = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] s_obs();
        return {s_de, s_blank, s_hs, s_vs, s_sof, s_eol, s_x, s_y};
    endfunction

    // Small mode: active x<4,y<3; HS high at x=5,6; VS high on y=4; EOL at x=7.
    function automatic logic [11:0] s_exp(input int x, input int y);
        logic de;
        de = (x < 4) && (y < 3);
        return {de, de, 1'(x == 5 || x == 6), 1'(y == 4),
                1'(x == 0 && y == 0), 1'(x == 7), 3'(x), 3'(y)};
    endfunction

    task automatic run_px();
        tick();
        chk($sformatf("small_px(%0d,%0d)", mx, my), 32'(s_obs()), 32'(s_exp(mx, my)));
        if (mx == 0 && my == 0) begin
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk("frame_cnt", 32'(s_fc), 32'(n_sof % 4));
`endif
            n_sof++;
        end
        if (mx == 7) begin
            mx = 0;
            my = (my == 5) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endtask

    initial begin
        int hs_low;
        int first_low;
        int eol_x;
        int de_cnt;
        hs_low    = 0;
        first_low = -1;
        eol_x     = -1;
        de_cnt    = 0;

        repeat (3) tick();
        chk("rst_small", 32'(s_obs()), 32'h0);
        chk("rst_def_syncs", {30'h0, d_hs, d_vs}, 32'h3);
        chk("rst_def_de_sof", {29'h0, d_de, d_sof, d_eol}, 32'h0);
        chk("vga_sync", {30'h0, s_sync, d_sync}, 32'h0);
        chk("vga_clk", {30'h0, s_vclk, d_vclk}, 32'h3);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("rst_fc", 32'(s_fc), 32'h0);
`endif

        RST  = 1'b1;
        s_en = 1'b1;
        d_en = 1'b1;
        tick();
        chk("start_idle_cycle", 32'(s_obs()), 32'h0);
        chk("start_def_no_sof", 32'(d_sof), 32'h0);

        for (int k = 0; k < 800; k++) begin
            run_px();
            if (k == 0) begin
                chk("def_first_px", {d_sof, d_de, d_x, d_y}, {2'b11, 20'h0});
            end
            if (!d_hs) begin
                hs_low++;
                if (first_low < 0) first_low = int'(d_x);
            end
            if (d_eol) eol_x = int'(d_x);
            if (d_blank) de_cnt++;
        end
        chk("def_hs_low_len", 32'(hs_low), 32'd96);
        chk("def_hs_first_x", 32'(first_low), 32'd656);
        chk("def_eol_x", 32'(eol_x), 32'd799);
        chk("def_de_per_line", 32'(de_cnt), 32'd640);
        chk("def_line0_y_vs", {d_y, d_vs}, {10'd0, 1'b1});
        d_en = 1'b0;

        for (int i = 0; i < 100 && my != 1; i++) run_px();
        s_en = 1'b0;
        for (int i = 0; i < 100 && !(mx == 0 && my == 0); i++) run_px();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stopped_idle", 32'(s_obs()), 32'h0);
        end

        s_en = 1'b1;
        tick();
        chk("restart_gap", 32'(s_obs()), 32'h0);
        for (int i = 0; i < 21; i++) run_px();

        RST = 1'b0;
        tick();
        chk("rst_mid_frame", 32'(s_obs()), 32'h0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("rst_mid_fc", 32'(s_fc), 32'h0);
`endif
        RST = 1'b1;
        mx = 0;
        my = 0;
        n_sof = 0;
        tick();
        chk("rst_release_gap", 32'(s_obs()), 32'h0);
        for (int i = 0; i < 49; i++) run_px();

        chk("def_idle_after_rst", {29'h0, d_hs, d_vs, d_de}, 32'h6);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("def_fc_after_rst", 32'(d_fc), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/DVI raster timing generator, the successor to the fixed 640x480 generator. Produces sync, blanking, data-enable, pixel coordinates and frame/line markers for any timing mode set at elaboration. Adds programmable sync polarity and a run/stop control that stops only at frame boundaries. Sits between the pixel clock domain and the frame-buffer reader and video DAC.

## Interface
- HDISP, 640, active pixels per line
- HFP / HPULSE / HBP, 16 / 96 / 48, horizontal front porch, sync, back porch (pixels)
- VDISP, 480, active lines per frame
- VFP / VPULSE / VBP, 10 / 2 / 33, vertical front porch, sync, back porch (lines)
- HS_POL / VS_POL, 0 / 0, sync level during pulse (0 = active-low)
- FCW, 16, frame counter width (used only with VGA_TIMING_FRAME_CNT_EN)
- Derived: HTOTAL = HDISP+HFP+HPULSE+HBP; VTOTAL likewise; XW = $clog2(HTOTAL); YW = $clog2(VTOTAL). All timing parameters ≥ 1.
- CLK  in  1  pixel clock
- RST  in  1  synchronous, active-low reset
- ENABLE  in  1  run request; stop takes effect at frame end
- VGA_CLK  out  1  equal to CLK
- VGA_HS / VGA_VS  out  1  sync, polarity per HS_POL / VS_POL
- VGA_BLANK  out  1  high in active area, low when blanking
- VGA_SYNC  out  1  tied 0
- DE  out  1  identical to VGA_BLANK; kept for DVI encoder
- X  out  XW  horizontal position 0..HTOTAL-1
- Y  out  YW  vertical position 0..VTOTAL-1
- SOF  out  1  one-cycle pulse at (0,0)
- EOL  out  1  one-cycle pulse at X = HTOTAL-1
- FRAME_CNT  out  FCW  frames started minus one (macro only)

## Operation
- Internal position (hc, vc) steps one pixel per enabled cycle. hc wraps HTOTAL-1→0. On that wrap, vc increments, wrapping VTOTAL-1→0.
- Horizontal regions: DISP hc<HDISP; FP <HDISP+HFP; PULSE <HDISP+HFP+HPULSE; BP otherwise. Vertical regions use the same rule on vc.
- DE = hDISP && vDISP. HS = HS_POL in hPULSE, otherwise ~HS_POL. VS = VS_POL in vPULSE, otherwise ~VS_POL. VS therefore changes only at hc = 0.
- Run/stop FSM with states IDLE and RUN:
  - IDLE→RUN when ENABLE = 1.
  - In RUN, ENABLE is sampled at (HTOTAL-1, VTOTAL-1). If it is 0, go to IDLE with position (0,0). Otherwise continue.
  - ENABLE low mid-frame never truncates a frame.
- While in IDLE:
  - Position holds at (0,0).
  - Outputs: DE = 0, HS = ~HS_POL, VS = ~VS_POL, X = 0, Y = 0, SOF = 0, EOL = 0.
- Reset (RST = 0 at an edge) overrides everything, including mid-frame:
  - Next cycle: FSM in IDLE, position (0,0), all outputs at their IDLE values, FRAME_CNT = 0.

## Timing
- All outputs except VGA_CLK and VGA_SYNC are registered. Outputs at cycle n describe the position reached at n-1, so latency is 1 cycle. All outputs for a given pixel are mutually aligned.
- First edge with RST = 1 and ENABLE = 1 (in IDLE): FSM enters RUN. The next cycle shows X=0, Y=0, DE=1, SOF=1.
- ENABLE re-asserted while in IDLE: SOF appears 2 cycles later.
- Line period is HTOTAL cycles; frame period is HTOTAL·VTOTAL cycles. No gaps between frames while ENABLE stays 1.
- EOL and SOF never coincide. EOL at (HTOTAL-1, VTOTAL-1) is followed directly by SOF when continuing.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined:
  - FRAME_CNT port and an FCW-bit counter exist.
  - The counter increments modulo 2^FCW on every SOF after the first since reset; the first SOF shows 0.
  - It is registered with the same alignment as SOF.
- Not defined: port and counter are absent; all other behaviour is identical.

## Structure
- Package vga_pkg: region enum {DISP, FP, PULSE, BP}, run-state enum {IDLE, RUN}, and default 640x480 timing constants.
- Sub-module vga_axis_counter, instantiated twice (horizontal and vertical):
  - Parameters: DISP, FP, PULSE, BP.
  - Inputs: CLK, RST, step, clear.
  - Outputs: count, region, wrap.
- The top level holds the run/stop FSM, output registers and the optional frame counter.

## Test plan
- Default parameters, reset then ENABLE = 1 → first active cycle X=0, Y=0, DE=1, SOF=1; per line HS low for exactly 96 cycles at X=656..751; EOL at X=799.
- Full frame → SOF period 420000 cycles; VS low for 1600 cycles starting at X=0, Y=490; DE high 307200 cycles per frame.
- ENABLE deasserted at Y=100 → frame runs to (799,524), then idle (DE=0, HS=VS=1, no SOF); ENABLE re-asserted → SOF 2 cycles later.
- RST low at X=300, Y=200 → next cycle all outputs at IDLE values; after release, restart at (0,0) with SOF.
- HDISP=4, HFP=1, HPULSE=2, HBP=1, VDISP=3, VFP=1, VPULSE=1, VBP=1, HS_POL=VS_POL=1 → HTOTAL=8; HS high only at X=5,6; VS high only on Y=4; SOF every 48 cycles.
- Macro defined, FCW=2, small mode above → FRAME_CNT sequence 0,1,2,3,0 on successive SOFs; undefined → no FRAME_CNT port and elaboration is clean.
